// File: rtl/video_ts_pkg.sv
// Shared constants and state type for the TS-line display reader.
package video_ts_pkg;

    localparam int unsigned TSL_DEPTH  = 512;
    localparam int unsigned TSL_AW     = 9;
    localparam logic [7:0]  TSL_TRANSP = 8'h00;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LINE
    } tsl_state_t;

endpackage

// File: rtl/video_ts_lbuf_bank.sv
// One 512x8 line-buffer bank: single write port, registered read port.
module video_ts_lbuf_bank
    import video_ts_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [TSL_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [TSL_AW-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [TSL_DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; output holds until the next read enable.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/video_ts_lineout.sv
// Display-side TS-line reader: bank swap per line, pixel readout,
// clear-on-read plus tail sweep so the next render bank starts transparent.
module video_ts_lineout
    import video_ts_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  x_start,
    input  logic [9:0]  x_len,
    input  logic        pix_stb,
    input  logic [8:0]  ts_waddr,
    input  logic [7:0]  ts_wdata,
    input  logic        ts_we,
    output logic [7:0]  ts_pix,
    output logic        ts_vld,
    output logic        init_busy,
    output logic        ovf
);

    tsl_state_t        state;
    logic              disp_sel;
    logic [TSL_AW-1:0] init_ptr;
    logic [TSL_AW-1:0] rd_ptr;
    logic [TSL_AW-1:0] xs_r;
    logic [TSL_AW-1:0] clr_addr;
    logic [9:0]        len_r;
    logic [9:0]        rd_cnt;
    logic [9:0]        sw_ptr;
    logic              clr_pend;
    logic              rd_vld_q;
    logic              rd_bank_q;

    logic              sw_done;
    logic              line_done;
    logic              rd_go;
    logic [TSL_AW-1:0] sw_off;
    logic              sw_hit;
    logic              disp_we;
    logic [TSL_AW-1:0] disp_waddr;
    logic              rend_we;

    logic              a_we, b_we, a_re, b_re;
    logic [TSL_AW-1:0] a_waddr, b_waddr;
    logic [7:0]        a_wdata, b_wdata;
    logic [7:0]        a_rdata, b_rdata;

    // Readout, sweep and write-port steering for the current cycle.
    always_comb begin
        sw_done    = sw_ptr[9];
        line_done  = (rd_cnt == len_r) && sw_done;
        rd_go      = (state == LINE) && pix_stb && !line_start && (rd_cnt < len_r);
        sw_off     = sw_ptr[TSL_AW-1:0] - xs_r;
        sw_hit     = (state == LINE) && !clr_pend && !sw_done && ({1'b0, sw_off} >= len_r);
        disp_we    = ((state == LINE) && clr_pend) || sw_hit;
        disp_waddr = clr_pend ? clr_addr : sw_ptr[TSL_AW-1:0];
        rend_we    = ts_we && (state != INIT);

        a_we    = 1'b0;
        a_waddr = '0;
        a_wdata = TSL_TRANSP;
        b_we    = 1'b0;
        b_waddr = '0;
        b_wdata = TSL_TRANSP;
        if (state == INIT) begin
            a_we    = 1'b1;
            a_waddr = init_ptr;
            b_we    = 1'b1;
            b_waddr = init_ptr;
        end else if (!disp_sel) begin
            a_we    = disp_we;
            a_waddr = disp_waddr;
            b_we    = rend_we;
            b_waddr = ts_waddr;
            b_wdata = ts_wdata;
        end else begin
            b_we    = disp_we;
            b_waddr = disp_waddr;
            a_we    = rend_we;
            a_waddr = ts_waddr;
            a_wdata = ts_wdata;
        end
        a_re = rd_go && !disp_sel;
        b_re = rd_go && disp_sel;
    end

    // Control FSM with line window, pointers and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_ptr  <= '0;
            init_busy <= 1'b1;
            disp_sel  <= 1'b0;
            ovf       <= 1'b0;
            rd_ptr    <= '0;
            xs_r      <= '0;
            len_r     <= '0;
            rd_cnt    <= '0;
            sw_ptr    <= '0;
            clr_pend  <= 1'b0;
            clr_addr  <= '0;
            rd_vld_q  <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            ovf      <= 1'b0;
            clr_pend <= 1'b0;
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    rd_vld_q <= 1'b0;
                    if (init_ptr == TSL_AW'(TSL_DEPTH - 1)) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                    end
                end
                IDLE, LINE: begin
                    if (line_start) begin
                        if ((state == LINE) && !line_done) begin
                            ovf <= 1'b1;
                        end
                        disp_sel <= ~disp_sel;
                        rd_ptr   <= x_start;
                        xs_r     <= x_start;
                        len_r    <= (x_len > 10'd512) ? 10'd512 : x_len;
                        rd_cnt   <= '0;
                        sw_ptr   <= '0;
                        state    <= LINE;
                    end else if (state == LINE) begin
                        if (rd_go) begin
                            rd_ptr    <= rd_ptr + 1'b1;
                            rd_cnt    <= rd_cnt + 10'd1;
                            clr_pend  <= 1'b1;
                            clr_addr  <= rd_ptr;
                            rd_vld_q  <= 1'b1;
                            rd_bank_q <= disp_sel;
                        end else if (pix_stb) begin
                            rd_vld_q <= 1'b0;
                        end
                        if (!clr_pend && !sw_done) begin
                            sw_ptr <= sw_ptr + 10'd1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign ts_pix = rd_vld_q ? (rd_bank_q ? b_rdata : a_rdata) : TSL_TRANSP;
    assign ts_vld = |ts_pix[3:0];

    video_ts_lbuf_bank u_bank_a (
        .clk   (clk),
        .we    (a_we),
        .waddr (a_waddr),
        .wdata (a_wdata),
        .re    (a_re),
        .raddr (rd_ptr),
        .rdata (a_rdata)
    );

    video_ts_lbuf_bank u_bank_b (
        .clk   (clk),
        .we    (b_we),
        .waddr (b_waddr),
        .wdata (b_wdata),
        .re    (b_re),
        .raddr (rd_ptr),
        .rdata (b_rdata)
    );

endmodule

// File: tb/tb_video_ts_lineout.sv
// Self-checking bench for video_ts_lineout against a line-level buffer model.
module tb_video_ts_lineout;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line_start = 1'b0;
    logic [8:0] x_start = '0;
    logic [9:0] x_len = '0;
    logic       pix_stb = 1'b0;
    logic [8:0] ts_waddr = '0;
    logic [7:0] ts_wdata = '0;
    logic       ts_we = 1'b0;
    logic [7:0] ts_pix;
    logic       ts_vld;
    logic       init_busy;
    logic       ovf;

    always #18 clk = ~clk;

    video_ts_lineout dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .x_start    (x_start),
        .x_len      (x_len),
        .pix_stb    (pix_stb),
        .ts_waddr   (ts_waddr),
        .ts_wdata   (ts_wdata),
        .ts_we      (ts_we),
        .ts_pix     (ts_pix),
        .ts_vld     (ts_vld),
        .init_busy  (init_busy),
        .ovf        (ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: two banks, index msel is the one being displayed.
    logic [7:0] mbank [2][512];
    int         msel;
    int         m_xs, m_len, m_cnt;
    logic [7:0] hold_pix;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) mbank[b][a] = 8'h00;
        msel = 0; m_xs = 0; m_len = 0; m_cnt = 0; hold_pix = 8'h00;
    endfunction

    // A completed line leaves its display bank fully transparent.
    function automatic void model_line_start(int xs, int len);
        for (int a = 0; a < 512; a++) mbank[msel][a] = 8'h00;
        msel  = 1 - msel;
        m_xs  = xs;
        m_len = (len > 512) ? 512 : len;
        m_cnt = 0;
    endfunction

    function automatic logic [7:0] model_read();
        logic [7:0] v;
        if (m_cnt < m_len) begin
            v = mbank[msel][(m_xs + m_cnt) % 512];
            m_cnt++;
        end else begin
            v = 8'h00;
        end
        hold_pix = v;
        return v;
    endfunction

    function automatic void model_write(int a, logic [7:0] d);
        mbank[1 - msel][a] = d;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one clock of inputs; outputs are valid for that edge on return.
    task automatic cyc(input logic ls, input logic [8:0] xs, input logic [9:0] xl,
                       input logic stb, input logic we, input logic [8:0] wa,
                       input logic [7:0] wd);
        line_start = ls; x_start = xs; x_len = xl;
        pix_stb = stb; ts_we = we; ts_waddr = wa; ts_wdata = wd;
        step();
        line_start = 1'b0; pix_stb = 1'b0; ts_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        step();
        n_tests++; if (ts_pix !== 8'h00) begin n_fail++; $display("FAIL reset_pix: got %h want 00", ts_pix); end
        n_tests++; if (ts_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", ts_vld); end
        n_tests++; if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", init_busy); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        reset = 1'b0;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 2000) begin
            cnt++;
            step();
        end
        n_tests++; if (cnt != 512) begin n_fail++; $display("FAIL init_len: got %0d clks want 512", cnt); end
        model_reset();
    endtask

    task automatic test_write_swap_read();
        logic [7:0] e;
        cyc(0, '0, '0, 0, 1, 9'd10, 8'h35);  model_write(10, 8'h35);
        cyc(0, '0, '0, 0, 1, 9'd11, 8'h70);  model_write(11, 8'h70);
        cyc(0, '0, '0, 0, 1, 9'd200, 8'hC3); model_write(200, 8'hC3);
        cyc(1, 9'd10, 10'd2, 0, 0, '0, '0);  model_line_start(10, 2);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wsr_ovf: got %b want 0", ovf); end
        for (int i = 0; i < 2; i++) begin
            cyc(0, '0, '0, 1, 0, '0, '0);
            e = model_read();
            n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL wsr_pix%0d: got %h want %h", i, ts_pix, e); end
            n_tests++; if (ts_vld !== (e[3:0] != 4'h0)) begin n_fail++; $display("FAIL wsr_vld%0d: got %b want %b", i, ts_vld, e[3:0] != 4'h0); end
        end
        idle(3);
        n_tests++; if (ts_pix !== hold_pix) begin n_fail++; $display("FAIL wsr_hold: got %h want %h", ts_pix, hold_pix); end
    endtask

    task automatic test_clear_sweep();
        logic [7:0] e;
        idle(600);
        cyc(1, 9'd0, 10'd0, 0, 0, '0, '0); model_line_start(0, 0);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL cs_ovf0: got %b want 0", ovf); end
        idle(600);
        cyc(1, 9'd10, 10'd191, 0, 0, '0, '0); model_line_start(10, 191);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL cs_ovf1: got %b want 0", ovf); end
        for (int i = 0; i < 192; i++) begin
            cyc(0, '0, '0, 1, 0, '0, '0);
            e = model_read();
            n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL cs_pix@%0d: got %h want %h", (10 + i) % 512, ts_pix, e); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        int addrs[4] = '{510, 511, 0, 1};
        for (int i = 0; i < 4; i++) begin
            e = 8'($urandom_range(255, 1));
            cyc(0, '0, '0, 0, 1, 9'(addrs[i]), e);
            model_write(addrs[i], e);
        end
        idle(700);
        cyc(1, 9'd510, 10'd4, 0, 0, '0, '0); model_line_start(510, 4);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, '0, 1, 0, '0, '0);
            e = model_read();
            n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL wrap_pix%0d: got %h want %h", i, ts_pix, e); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e, wd;
        logic [8:0] xs, wa;
        logic [9:0] xl;
        logic       stb, we;
        int         cycles, reads;
        idle(600);
        for (int ln = 0; ln < 8; ln++) begin
            xs = 9'($urandom_range(511));
            case (ln)
                0:       xl = 10'd0;
                1:       xl = 10'd512;
                2:       xl = 10'd700;
                default: xl = 10'($urandom_range(512));
            endcase
            cyc(1, xs, xl, 0, 0, '0, '0);
            model_line_start(int'(xs), int'(xl));
            n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_ovf line%0d: got %b want 0", ln, ovf); end
            cycles = 0; reads = 0;
            while (!(cycles >= 1100 && reads > m_len)) begin
                stb = (cycles >= 900) || ($urandom_range(1) == 1);
                if (reads > m_len + 1) stb = 1'b0;
                we = ($urandom_range(2) == 0);
                wa = 9'($urandom_range(511));
                wd = 8'($urandom_range(255));
                cyc(0, '0, '0, stb, we, wa, wd);
                if (we) model_write(int'(wa), wd);
                if (stb) begin
                    e = model_read();
                    reads++;
                    n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL rnd_pix line%0d rd%0d: got %h want %h", ln, reads, ts_pix, e); end
                    n_tests++; if (ts_vld !== (e[3:0] != 4'h0)) begin n_fail++; $display("FAIL rnd_vld line%0d rd%0d: got %b want %b", ln, reads, ts_vld, e[3:0] != 4'h0); end
                end
                cycles++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e, held;
        logic [8:0] xs;
        idle(600);
        xs = 9'($urandom_range(511));
        cyc(0, '0, '0, 0, 1, xs, 8'h12);        model_write(int'(xs), 8'h12);
        cyc(0, '0, '0, 0, 1, xs + 9'd1, 8'h9F); model_write(int'(xs + 9'd1), 8'h9F);
        held = hold_pix;
        cyc(1, xs, 10'd2, 1, 0, '0, '0); model_line_start(int'(xs), 2);
        n_tests++; if (ts_pix !== held) begin n_fail++; $display("FAIL sim_noread: got %h want %h", ts_pix, held); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, '0, 1, 0, '0, '0);
            e = model_read();
            n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL sim_pix%0d: got %h want %h", i, ts_pix, e); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        logic [8:0] xs;
        idle(600);
        xs = 9'($urandom_range(511));
        cyc(1, xs, 10'd360, 0, 0, '0, '0); model_line_start(int'(xs), 360);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", ovf); end
        for (int i = 0; i < 99; i++) begin
            cyc(0, '0, '0, (i < 50), (i == 60), 9'd300, 8'h5A);
            if (i == 60) model_write(300, 8'h5A);
            if (i < 50) begin
                e = model_read();
                n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL ovf_rd%0d: got %h want %h", i, ts_pix, e); end
            end
        end
        cyc(1, 9'd300, 10'd1, 0, 0, '0, '0); model_line_start(300, 1);
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
        cyc(0, '0, '0, 1, 0, '0, '0);
        e = model_read();
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_width: got %b want 0", ovf); end
        n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL ovf_swap: got %h want %h", ts_pix, e); end
    endtask

    task automatic test_reset_midline();
        logic [7:0] e;
        int cnt;
        for (int i = 0; i < 20; i++) begin
            e = 8'($urandom_range(255, 1));
            cyc(0, '0, '0, 0, 1, 9'(i * 7), e);
        end
        cyc(1, 9'd0, 10'd512, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) cyc(0, '0, '0, 1, 1, 9'(i * 3), 8'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 2000) begin
            n_tests++; if (ts_vld !== 1'b0 || ts_pix !== 8'h00) begin n_fail++; $display("FAIL mid_init_out clk%0d: got pix %h vld %b want 00/0", cnt, ts_pix, ts_vld); end
            cnt++;
            cyc(1'($urandom_range(1)), 9'($urandom_range(511)), 10'($urandom_range(512)),
                1'($urandom_range(1)), 1'b1, 9'($urandom_range(511)), 8'($urandom_range(255, 1)));
        end
        n_tests++; if (cnt != 512) begin n_fail++; $display("FAIL mid_init_len: got %0d clks want 512", cnt); end
        model_reset();
        for (int ln = 0; ln < 2; ln++) begin
            cyc(1, 9'(ln * 100), 10'd512, 0, 0, '0, '0); model_line_start(ln * 100, 512);
            n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf line%0d: got %b want 0", ln, ovf); end
            for (int i = 0; i < 512; i++) begin
                cyc(0, '0, '0, 1, 0, '0, '0);
                e = model_read();
                n_tests++; if (ts_pix !== e) begin n_fail++; $display("FAIL mid_clear bank%0d rd%0d: got %h want %h", ln, i, ts_pix, e); end
            end
            idle(600);
        end
    endtask

    initial begin
        model_reset();
        step();
        test_reset();
        test_write_swap_read();
        test_clear_sweep();
        test_wrap();
        test_random();
        test_simultaneous();
        test_overflow();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
